fixed_point_onehot_arbiter: RTL and testbench
=============================================

// Module: fixed_point_onehot_arbiter
// PURPOSE
//  Shares one fixed-point datapath among N requesters. A round-robin arbiter picks one requester
//  and drives a one-hot grant into a one-hot data mux. The selected value goes to a single output
//  register with a valid/ready handshake.
//  Sits in front of the shared fixed-point consumer and sequences access to it.
// PARAMETERS
//  N      4   number of requesters (>=2)
//  W     16   fixed-point word width, in bits
//  FRAC   8   fractional bits (binary point). The value passes through unchanged; FRAC is metadata only.
// PORTS
//  clock      in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-high; clears all state immediately
//  in_valid   in   N        requester i has a word available
//  in_ready   out  N        requester i's word is accepted this cycle (one-hot or zero)
//  in_data    in   N*W      packed words; requester i occupies [i*W +: W]
//  in_lock    in   N        hold the grant on i after this beat (present only with ARB_LOCK_EN)
//  out_valid  out  1        output register holds a word
//  out_ready  in   1        consumer accepts the output word
//  out_data   out  W        selected fixed-point word (signed two's complement, FRAC fraction bits)
//  out_grant  out  N        one-hot source of out_data
//  out_id     out  $clog2(N)  binary index of out_grant
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_grant=0, out_id=0, priority pointer ptr=0, lock=0.
//    in_ready is combinational and is 0 while reset is asserted.
//  - load = !out_valid || out_ready. The output register accepts a new word whenever it is empty or draining.
//  - Grant: grant = the first set bit of in_valid scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//    grant is always one-hot or zero. in_ready = grant & {N{load}}.
//  - Accept (load && |grant):
//    - out_data <= one-hot mux (OR of in_data[i] & {W{grant[i]}}).
//    - out_grant <= grant; out_id <= index; out_valid <= 1.
//    - ptr <= (index+1) mod N, which wraps N-1 -> 0.
//  - load && !|in_valid: out_valid <= 0; out_data/out_grant/out_id hold their last values.
//  - !load (out_valid && !out_ready): all output registers and ptr hold; in_ready=0.
//  - Latency: 1 cycle from in_valid&in_ready to out_valid.
//  - Throughput: 1 word/cycle. Pop and push in the same cycle is legal; the register is overwritten.
//  - Fairness: each requester that keeps in_valid asserted is granted within N accepts.
//  - in_valid may drop without a handshake. No word is lost, because nothing is taken without in_ready.
//  - Reset mid-transfer: the word in the output register is discarded and arbitration restarts at requester 0.
//  - States (2): EMPTY (out_valid=0) and FULL (out_valid=1).
//    EMPTY->FULL on accept. FULL->EMPTY on out_ready with no request. FULL->FULL on out_ready with a request.
//    FULL holds on !out_ready.
// CONFIGURATION
//  - ARB_LOCK_EN defined: the in_lock port exists.
//    - An accept with in_lock[index]=1 sets lock and pins the grant to index. Other requests are masked.
//    - The lock clears on the first accept from index with in_lock=0; ptr advances only then.
//    - While locked, in_valid[index]=0 produces no grant (bubbles) and does not release the lock.
//    - Use: multi-beat fixed-point vectors that must stay contiguous.
//  - ARB_LOCK_EN undefined: no in_lock port and no lock register; pure round-robin on every beat.
// STRUCTURE
//  - Package fxp_arb_pkg:
//    - ID_W = $clog2(N) helper function;
//    - onehot_to_idx function;
//    - fixed-point word typedef (logic signed [W-1:0]) with FRAC localparam.
//  - Sub-module rr_priority_picker (N): inputs req and ptr; output one-hot grant and idx. Purely combinational.
//  - The top holds ptr, the lock, the output register and the one-hot mux.
// TESTING (N=4, W=16, FRAC=8)
//  - Single requester:
//    - Stimulus: in_valid=4'b0100, in_data[2]=16'h0180 (1.5), out_ready=1.
//    - Response: next cycle out_valid=1, out_data=16'h0180, out_grant=4'b0100, out_id=2.
//  - Round-robin:
//    - Stimulus: in_valid=4'b1111 held, out_ready=1, from reset.
//    - Response: out_id sequence 0,1,2,3,0 with one word per cycle.
//  - Backpressure:
//    - Stimulus: out_ready=0 for 3 cycles while FULL with data 16'hFF80 (-0.5).
//    - Response: in_ready=0 and out_data is stable for all 3 cycles; ptr is unchanged.
//  - Wrap and skip:
//    - Stimulus: ptr=3, in_valid=4'b0010.
//    - Response: grant=4'b0010, then ptr becomes 2.
//  - Reset mid-operation:
//    - Stimulus: assert reset while out_valid=1 and out_ready=0.
//    - Response: out_valid=0 and out_grant=0 immediately, without waiting for a clock edge.
//      After release, the first grant goes to requester 0.
//  - ARB_LOCK_EN:
//    - Stimulus: in_valid=4'b0011, in_lock[1]=1 for 3 beats, then 0.
//    - Response: four consecutive words from requester 1 before requester 0 is granted.

Source files
------------

// File: rtl/fixed_point_onehot_arbiter_pkg.sv
// Shared types and helpers for the fixed-point one-hot round-robin arbiter.
// Build option: define ARB_LOCK_EN to enable the multi-beat grant lock.
package fxp_arb_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 16;
    localparam int FRAC  = 8;

    // Signed two's-complement word with FRAC fraction bits.
    typedef logic signed [W_DEF-1:0] fxp_word_t;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // OR of set-bit positions; exact for one-hot input, 0 for all-zero input.
    function automatic int onehot_to_idx(input logic [63:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fixed_point_onehot_arbiter_if.sv
// Requester and consumer bundle of the arbiter; slave is the arbiter side.
// Build option: in_lock exists only when ARB_LOCK_EN is defined.
interface fixed_point_onehot_arbiter_if
    import fxp_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
);
    localparam int ID_W = id_w(N);

    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*W-1:0]  in_data;
`ifdef ARB_LOCK_EN
    logic [N-1:0]    in_lock;
`endif
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [N-1:0]    out_grant;
    logic [ID_W-1:0] out_id;

    modport master (
        output in_valid, in_data,
`ifdef ARB_LOCK_EN
        output in_lock,
`endif
        output out_ready,
        input  in_ready, out_valid, out_data, out_grant, out_id
    );

    modport slave (
        input  in_valid, in_data,
`ifdef ARB_LOCK_EN
        input  in_lock,
`endif
        input  out_ready,
        output in_ready, out_valid, out_data, out_grant, out_id
    );

endinterface

// File: rtl/fixed_point_onehot_arbiter_picker.sv
// Combinational round-robin picker: first set request scanning from ptr upward,
// wrapping at N-1; returns a one-hot grant and its binary index.
module rr_priority_picker
    import fxp_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         req_i,
    input  logic [id_w(N)-1:0]   ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [id_w(N)-1:0]   idx_o
);
    localparam int ID_W = id_w(N);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % N]) begin
                grant_o[(int'(ptr_i) + k) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign idx_o = ID_W'(onehot_to_idx(64'(grant_o)));

endmodule

// File: rtl/fixed_point_onehot_arbiter.sv
// Round-robin one-hot arbiter feeding one fixed-point output register (valid/ready).
// Build option: ARB_LOCK_EN pins the grant to a requester across locked beats.
module fixed_point_onehot_arbiter
    import fxp_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    fixed_point_onehot_arbiter_if.slave   bus
);
    localparam int ID_W = id_w(N);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]    req, grant;
    logic [ID_W-1:0] idx, idx_next;
    logic [W-1:0]    mux_data;
    logic            load;

`ifdef ARB_LOCK_EN
    logic            lock_q, lock_d;
    logic [ID_W-1:0] lock_idx_q, lock_idx_d;

    // While locked, only the owner may be granted; its absence is a bubble.
    always_comb begin
        req = bus.in_valid;
        if (lock_q) req = bus.in_valid & (N'(1) << lock_idx_q);
    end
`else
    assign req = bus.in_valid;
`endif

    rr_priority_picker #(.N(N)) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (idx)
    );

    assign load     = (state_q == EMPTY) || bus.out_ready;
    assign idx_next = (idx == ID_W'(N - 1)) ? '0 : idx + 1'b1;
    assign bus.in_ready = grant & {N{load && !rst}};

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            mux_data = mux_data | (bus.in_data[i*W +: W] & {W{grant[i]}});
        end
    end

    always_comb begin
        // NOTE: every _d starts at its hold value, so no branch can leave one unassigned and infer a latch.
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
`ifdef ARB_LOCK_EN
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
`endif
        if (load) begin
            if (|grant) begin
                state_d = FULL;
                data_d  = mux_data;
                grant_d = grant;
                id_d    = idx;
`ifdef ARB_LOCK_EN
                if (bus.in_lock[idx]) begin
                    lock_d     = 1'b1;
                    lock_idx_d = idx;
                end else begin
                    lock_d = 1'b0;
                    ptr_d  = idx_next;
                end
`else
                ptr_d = idx_next;
`endif
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
`ifdef ARB_LOCK_EN
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates make every register sample the same pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
`ifdef ARB_LOCK_EN
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_grant = grant_q;
    assign bus.out_id    = id_q;

endmodule

// File: tb/tb_fixed_point_onehot_arbiter.sv
// Directed bench for fixed_point_onehot_arbiter (N=4, W=16, FRAC=8); lock beats run when ARB_LOCK_EN is defined.
module tb_fixed_point_onehot_arbiter;
    import fxp_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    logic [W-1:0] words [N];

    fixed_point_onehot_arbiter_if #(.N(N), .W(W)) bus ();

    fixed_point_onehot_arbiter #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, obs, exp, n_fail);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [W-1:0] v);
        words[i] = v;
        bus.in_data[i*W +: W] = v;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = '1;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
        bus.in_lock   = '0;
`endif
        for (int i = 0; i < N; i++) words[i] = '0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_grant", 32'(bus.out_grant), 32'h0);
        check("rst_out_id",    32'(bus.out_id),    32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h0);
        tick();
        rst = 1'b0;

        // Single requester 2 carrying 1.5
        bus.in_valid  = 4'b0100;
        set_word(2, 16'h0180);
        bus.out_ready = 1'b1;
        #1;
        check("single_in_ready", 32'(bus.in_ready), 32'h4);
        tick();
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_data",  32'(bus.out_data),  32'h0180);
        check("single_grant", 32'(bus.out_grant), 32'h4);
        check("single_id",    32'(bus.out_id),    32'd2);

        // No request while draining: empty, payload registers hold
        bus.in_valid = 4'b0000;
        tick();
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_data",  32'(bus.out_data),  32'h0180);
        check("drain_grant", 32'(bus.out_grant), 32'h4);
        check("drain_id",    32'(bus.out_id),    32'd2);

        // ptr is 3; only requester 1 asks: wrap past 0, ptr -> 2
        bus.in_valid = 4'b0010;
        set_word(1, 16'h1234);
        #1;
        check("wrap_in_ready", 32'(bus.in_ready), 32'h2);
        tick();
        check("wrap_grant", 32'(bus.out_grant), 32'h2);
        check("wrap_id",    32'(bus.out_id),    32'd1);
        check("wrap_data",  32'(bus.out_data),  32'h1234);
        set_word(0, 16'h0100);
        set_word(1, 16'hFE00);
        set_word(2, 16'h0040);
        set_word(3, 16'h7FFF);
        bus.in_valid = 4'b1111;
        #1;
        check("wrap_ptr2_in_ready", 32'(bus.in_ready), 32'h4);
        tick();
        check("wrap_ptr2_id",   32'(bus.out_id),   32'd2);
        check("wrap_ptr2_data", 32'(bus.out_data), 32'h0040);

        // Round-robin from reset with all requesters active
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("rr_first_in_ready", 32'(bus.in_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_valid", 32'(bus.out_valid), 32'd1);
            check("rr_id",    32'(bus.out_id),    32'(k % N));
            check("rr_grant", 32'(bus.out_grant), 32'(1 << (k % N)));
            check("rr_data",  32'(bus.out_data),  32'(words[k % N]));
        end

        // Backpressure on -0.5 from requester 1 (ptr becomes 2)
        bus.in_valid = 4'b0010;
        set_word(1, 16'hFF80);
        tick();
        check("bp_load_data", 32'(bus.out_data), 32'hFF80);
        check("bp_load_id",   32'(bus.out_id),   32'd1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
            tick();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data",  32'(bus.out_data),  32'hFF80);
            check("bp_id",    32'(bus.out_id),    32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_ptr_in_ready", 32'(bus.in_ready), 32'h4);
        tick();
        check("bp_after_id",   32'(bus.out_id),   32'd2);
        check("bp_after_data", 32'(bus.out_data), 32'h0040);

        // Asynchronous reset while FULL and stalled
        bus.out_ready = 1'b0;
        tick();
        check("mid_full_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
        check("mid_rst_grant",    32'(bus.out_grant), 32'h0);
        check("mid_rst_in_ready", 32'(bus.in_ready),  32'h0);
        tick();
        check("mid_rst_hold_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("mid_release_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("mid_release_id",    32'(bus.out_id),    32'd0);
        check("mid_release_grant", 32'(bus.out_grant), 32'h1);

`ifdef ARB_LOCK_EN
        // ptr is 1: requester 1 locks for 3 beats, releases on the 4th
        bus.in_valid = 4'b0011;
        bus.in_lock  = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            tick();
            check("lock_beat_id", 32'(bus.out_id), 32'd1);
        end
        bus.in_lock = 4'b0000;
        tick();
        check("lock_last_id", 32'(bus.out_id), 32'd1);
        tick();
        check("lock_after_id",   32'(bus.out_id),   32'd0);
        check("lock_after_data", 32'(bus.out_data), 32'h0100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
